// File: rtl/panda_risc_v_ifu_fetch_queue_if.sv
// Fetch-queue bus bundle: IMEM request/response channel plus the result stream to pre-decode.
// The master modport is the fetch queue side; the slave modport is the bus/consumer side.
interface panda_risc_v_ifu_fetch_queue_if;
    logic [31:0] imem_access_req_addr;
    logic        imem_access_req_valid;
    logic        imem_access_req_ready;
    logic [31:0] imem_access_resp_rdata;
    logic [1:0]  imem_access_resp_err;
    logic        imem_access_resp_valid;
    logic [63:0] if_res_data;
    logic [1:0]  if_res_err;
    logic        if_res_valid;
    logic        if_res_ready;

    modport master (
        output imem_access_req_addr, imem_access_req_valid,
        input  imem_access_req_ready,
        input  imem_access_resp_rdata, imem_access_resp_err, imem_access_resp_valid,
        output if_res_data, if_res_err, if_res_valid,
        input  if_res_ready
    );

    modport slave (
        input  imem_access_req_addr, imem_access_req_valid,
        output imem_access_req_ready,
        output imem_access_resp_rdata, imem_access_resp_err, imem_access_resp_valid,
        input  if_res_data, if_res_err, if_res_valid,
        output if_res_ready
    );
endinterface

// File: rtl/panda_risc_v_ifu_fetch_queue.sv
// PANDA RISC-V IFU fetch queue: credit-based sequential fetch, in-order response matching, result FIFO.
// Optional zero-latency result bypass when PANDA_RISC_V_IFU_FETCH_BYPASS_EN is defined.
module panda_risc_v_ifu_fetch_queue #(
    parameter int          BUF_DEPTH        = 4,
    parameter logic [31:0] RESET_PC         = 32'h0000_0000,
    parameter int          simulation_delay = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_req,
    input  logic [31:0] flush_addr,
    panda_risc_v_ifu_fetch_queue_if.master bus,
    output logic        fetch_halted,
    output logic [4:0]  inflight_n
);
    localparam int PW = $clog2(BUF_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [1:0]  err;
    } res_t;

    logic [31:0]   pc_reg;
    logic [4:0]    live_n, stale_n, fifo_cnt;
    logic          halted;
    logic [31:0]   pcq [BUF_DEPTH];
    logic [PW-1:0] pcq_wr, pcq_rd;
    res_t          fifo [BUF_DEPTH];
    logic [PW-1:0] fifo_wr, fifo_rd;

    logic       credit_ok, req_fire, resp_drop, resp_take;
    logic       fifo_empty, fifo_push, fifo_pop, bypass, res_valid;
    logic [5:0] occupancy;
    res_t       head, resp_entry;

    // Kept only so existing instantiations that pass it still elaborate.
    logic unused_sim_delay;
    assign unused_sim_delay = (simulation_delay != 0);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Stale requests still hold credit so a dropped response can never find the FIFO short of room.
    assign occupancy = 6'(live_n) + 6'(stale_n) + 6'(fifo_cnt);
    assign credit_ok = occupancy < 6'(BUF_DEPTH);

    assign bus.imem_access_req_valid = credit_ok & ~halted & ~flush_req;
    assign bus.imem_access_req_addr  = pc_reg;
    assign req_fire   = bus.imem_access_req_valid & bus.imem_access_req_ready;

    assign resp_drop  = bus.imem_access_resp_valid & (stale_n != 5'd0);
    assign resp_take  = bus.imem_access_resp_valid & (stale_n == 5'd0) & ~flush_req;
    assign resp_entry = {pcq[pcq_rd], bus.imem_access_resp_rdata, bus.imem_access_resp_err};

    assign fifo_empty = (fifo_cnt == 5'd0);

`ifdef PANDA_RISC_V_IFU_FETCH_BYPASS_EN
    assign bypass    = resp_take & fifo_empty & bus.if_res_ready;
    assign res_valid = ~flush_req & (~fifo_empty | bypass);
    assign head      = fifo_empty ? resp_entry : fifo[fifo_rd];
`else
    assign bypass    = 1'b0;
    assign res_valid = ~flush_req & ~fifo_empty;
    assign head      = fifo[fifo_rd];
`endif

    assign fifo_push = resp_take & ~bypass;
    assign fifo_pop  = res_valid & bus.if_res_ready & ~fifo_empty;

    assign bus.if_res_valid = res_valid;
    assign bus.if_res_data  = {head.pc, head.inst};
    assign bus.if_res_err   = head.err;
    assign fetch_halted     = halted;
    assign inflight_n       = live_n + stale_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg   <= RESET_PC;
            live_n   <= '0;
            stale_n  <= '0;
            fifo_cnt <= '0;
            pcq_wr   <= '0;
            pcq_rd   <= '0;
            fifo_wr  <= '0;
            fifo_rd  <= '0;
            halted   <= 1'b0;
        end else if (flush_req) begin
            // Everything live becomes stale, minus a response that lands in this very cycle.
            pc_reg   <= flush_addr;
            live_n   <= '0;
            stale_n  <= stale_n + live_n - 5'(bus.imem_access_resp_valid);
            fifo_cnt <= '0;
            pcq_wr   <= '0;
            pcq_rd   <= '0;
            fifo_wr  <= '0;
            fifo_rd  <= '0;
            halted   <= 1'b0;
        end else begin
            if (req_fire) begin
                pc_reg <= pc_reg + 32'd4;
                pcq_wr <= ptr_inc(pcq_wr);
            end
            if (resp_take) pcq_rd <= ptr_inc(pcq_rd);
            if (resp_drop) stale_n <= stale_n - 5'd1;
            if (fifo_push) fifo_wr <= ptr_inc(fifo_wr);
            if (fifo_pop)  fifo_rd <= ptr_inc(fifo_rd);
            live_n   <= live_n + 5'(req_fire) - 5'(resp_take);
            fifo_cnt <= fifo_cnt + 5'(fifo_push) - 5'(fifo_pop);
            if (resp_take && bus.imem_access_resp_err != 2'b00) halted <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && req_fire)  pcq[pcq_wr]   <= pc_reg;
        if (!rst && fifo_push) fifo[fifo_wr] <= resp_entry;
    end
endmodule

// File: tb/tb_panda_risc_v_ifu_fetch_queue.sv
// Bench for panda_risc_v_ifu_fetch_queue: random bus/consumer/flush traffic against a transaction-level model.
module tb_panda_risc_v_ifu_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0100;
`ifdef PANDA_RISC_V_IFU_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_req = 1'b0;
    logic [31:0] flush_addr = '0;
    logic        fetch_halted;
    logic [4:0]  inflight_n;

    panda_risc_v_ifu_fetch_queue_if fq_if ();

    panda_risc_v_ifu_fetch_queue #(.BUF_DEPTH(DEPTH), .RESET_PC(RPC), .simulation_delay(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_req    (flush_req),
        .flush_addr   (flush_addr),
        .bus          (fq_if.master),
        .fetch_halted (fetch_halted),
        .inflight_n   (inflight_n)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] rdata; logic [1:0] err; int due; } bus_t;
    typedef struct { logic [31:0] pc; bit stale; } out_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; logic [1:0] err; } res_t;

    bus_t bq[$];     // requests accepted by the bus model, awaiting response
    out_t m_out[$];  // every request not yet answered, tagged stale once flushed
    res_t m_res[$];  // results owed to pre-decode, in order
    logic [31:0] m_pc;
    bit          m_halted;

    int errs = 0, checks = 0, cyc = 0, n_req = 0;
    int k_bus = 100, k_res = 100, k_lat_min = 2, k_lat_max = 2, k_err = 0, k_flush = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    bit          force_flush = 0;
    logic [31:0] force_addr = '0;
    bit          seen_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic cycle();
        bit rv, exp_rv, exp_ov, byp_now;
        res_t r;
        out_t o;
        bus_t b;
        int   lat;
        logic [1:0] e;
        rv = (bq.size() != 0) && (bq[0].due <= cyc);
        fq_if.imem_access_resp_valid = rv;
        fq_if.imem_access_resp_rdata = rv ? bq[0].rdata : $urandom;
        fq_if.imem_access_resp_err   = rv ? bq[0].err : 2'($urandom);
        fq_if.imem_access_req_ready  = ($urandom_range(99) < k_bus);
        fq_if.if_res_ready           = ($urandom_range(99) < k_res);
        flush_req  = force_flush || ($urandom_range(99) < k_flush);
        flush_addr = force_flush ? force_addr : ($urandom & 32'hFFFF_FFFC);
        force_flush = 0;
        @(negedge clk);

        exp_rv = !m_halted && !flush_req && (m_out.size() + m_res.size() < DEPTH);
        check("req_valid", fq_if.imem_access_req_valid, exp_rv);
        if (exp_rv) check("req_addr", fq_if.imem_access_req_addr, m_pc);
        check("inflight_n", inflight_n, m_out.size());
        check("fetch_halted", fetch_halted, m_halted);
        if (rv) check("resp_legal", inflight_n != 0, 1);

        byp_now = BYP && !flush_req && m_res.size() == 0 && rv && m_out.size() != 0
                  && !m_out[0].stale && fq_if.if_res_ready;
        exp_ov = !flush_req && (m_res.size() != 0 || byp_now);
        check("res_valid", fq_if.if_res_valid, exp_ov);
        if (exp_ov) begin
            if (m_res.size() != 0) r = m_res[0];
            else r = '{m_out[0].pc, fq_if.imem_access_resp_rdata, fq_if.imem_access_resp_err};
            check("res_data", fq_if.if_res_data, {r.pc, r.inst});
            check("res_err", fq_if.if_res_err, r.err);
            if (fq_if.if_res_ready) begin
                if (r.err == 2'b10 && r.pc == 32'h108) seen_err = 1;
                if (m_res.size() != 0) void'(m_res.pop_front());
            end
        end

        if (rv) begin
            b = bq.pop_front();
            if (m_out.size() != 0) begin
                o = m_out.pop_front();
                if (!o.stale && !flush_req) begin
                    if (!byp_now) m_res.push_back('{o.pc, b.rdata, b.err});
                    if (b.err != 2'b00) m_halted = 1;
                end
            end
        end
        if (flush_req) begin
            foreach (m_out[i]) m_out[i].stale = 1;
            m_res.delete();
            m_pc = flush_addr;
            m_halted = 0;
        end
        if (fq_if.imem_access_req_valid && fq_if.imem_access_req_ready) begin
            lat = $urandom_range(k_lat_max, k_lat_min);
            if (fq_if.imem_access_req_addr == err_addr) e = 2'b10;
            else if ($urandom_range(99) < k_err) e = 2'($urandom_range(3, 1));
            else e = 2'b00;
            bq.push_back('{fq_if.imem_access_req_addr, $urandom, e, cyc + lat});
            n_req++;
            if (!flush_req) begin
                m_out.push_back('{m_pc, 1'b0});
                m_pc += 32'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        bit found;
        int pre;
        fq_if.imem_access_req_ready  = 0;
        fq_if.imem_access_resp_valid = 0;
        fq_if.imem_access_resp_rdata = '0;
        fq_if.imem_access_resp_err   = '0;
        fq_if.if_res_ready           = 0;

        // Reset: outputs quiet, PC loaded.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_res_valid", fq_if.if_res_valid, 0);
        check("rst_halted", fetch_halted, 0);
        check("rst_inflight", inflight_n, 0);
        check("rst_addr", fq_if.imem_access_req_addr, RPC);
        @(posedge clk);
        #1;
        rst = 0;
        m_pc = RPC;
        m_halted = 0;

        // Steady streaming from RESET_PC, latency 2.
        repeat (40) cycle();

        // Consumer stalled: exactly DEPTH requests, then one more per pop.
        k_res = 0;
        force_flush = 1; force_addr = 32'h3000;
        cycle();
        n_req = 0;
        repeat (20) cycle();
        check("stall_req_cnt", n_req, DEPTH);
        k_res = 100;
        cycle();
        k_res = 0;
        repeat (10) cycle();
        check("one_pop_one_req", n_req, DEPTH + 1);

        // Flush with 3 requests in flight.
        k_res = 100; k_lat_min = 3; k_lat_max = 3;
        force_flush = 1; force_addr = 32'h1000;
        cycle();
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (inflight_n == 5'd3) begin
                found = 1; force_flush = 1; force_addr = 32'h2000;
            end
            cycle();
        end
        check("flush3_reached", found, 1);
        repeat (30) cycle();
        check("stale_drained", inflight_n <= 5'd3, 1);

        // Bus error on pc 0x108 halts fetch; flush to 0 resumes.
        k_lat_min = 2; k_lat_max = 2; err_addr = 32'h108;
        force_flush = 1; force_addr = 32'h100;
        cycle();
        repeat (20) cycle();
        check("err_halted", fetch_halted, 1);
        check("err_delivered", seen_err, 1);
        err_addr = 32'hFFFF_FFFF;
        force_flush = 1; force_addr = 32'h0;
        cycle();
        repeat (10) cycle();
        check("halt_cleared", fetch_halted, 0);

        // Response coinciding with flush is not buffered.
        k_lat_min = 3; k_lat_max = 3;
        force_flush = 1; force_addr = 32'h500;
        cycle();
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (bq.size() != 0 && bq[0].due <= cyc && m_out.size() > 1 && !m_out[0].stale
                && !m_out[1].stale) begin
                found = 1; force_flush = 1; force_addr = 32'h4000;
                pre = m_out.size();
            end
            cycle();
        end
        check("flush_resp_found", found, 1);
        if (found) check("flush_resp_stale", inflight_n, pre - 1);

        // Random traffic.
        k_bus = 70; k_res = 60; k_lat_min = 1; k_lat_max = 4; k_err = 2; k_flush = 2;
        repeat (3000) cycle();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
